alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
- REQ-001 Parameter N_BITS, default 8: operand and internal result width.
- REQ-002 Parameter N_LEDS, default 8: o_res width.
- REQ-003 Ports SHALL be, in order:
  - i_clk  input  1  sole clock, rising edge.
  - i_reset  input  1  asynchronous, active-high reset.
  - i_A  input  N_BITS  operand A.
  - i_B  input  N_BITS  operand B, also the shift amount.
  - i_Op  input  6  opcode.
  - o_res  output  N_LEDS  registered result.
  - o_zero, o_carry, o_overflow  output  1 each  registered status flags.
- REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; there are no other clocks or resets.

Function
- REQ-005 Opcodes SHALL decode as:
  - 6'b100000 ADD: A+B
  - 6'b100010 SUB: A-B
  - 6'b100100 AND
  - 6'b100101 OR
  - 6'b100110 XOR
  - 6'b100111 NOR: ~(A|B)
  - 6'b000010 SRL: A logically shifted right by B
  - 6'b000011 SRA: A arithmetically shifted right by B
- REQ-006 Any other opcode SHALL produce result 0 and flags 0.
- REQ-007 o_res SHALL be the combinational result sampled at each rising i_clk edge, giving one-cycle latency with no handshake; a new operation is accepted every cycle.
- REQ-008 Arithmetic SHALL be modulo 2^N_BITS, with operands treated as two's complement for overflow and SRA.
- REQ-009 Shift amounts ≥ N_BITS SHALL saturate: SRL gives 0; SRA gives all bits equal to A[N_BITS-1].
- REQ-010 The N_BITS result SHALL map to o_res truncated (N_LEDS<N_BITS) or zero-extended (N_LEDS>N_BITS).
- REQ-011 If inputs change between edges, o_res SHALL reflect only values present at the sampling edge.

Reset
- REQ-012 While i_reset=1, o_res, o_zero, o_carry and o_overflow SHALL be 0 immediately, independent of i_clk.
- REQ-013 After i_reset deasserts, the first rising edge SHALL register the current operation normally.
- REQ-014 Reset asserted mid-stream SHALL discard any pending result.

Configuration
- REQ-015 Macro ALU_CORE_FLAGS_EN, when defined, SHALL enable the registered flags with the same latency as o_res:
  - o_zero = (result==0)
  - o_carry = carry-out for ADD, NOT borrow for SUB, 0 for all other ops
  - o_overflow = signed overflow for ADD/SUB, 0 for all other ops
- REQ-016 Without ALU_CORE_FLAGS_EN, the flag ports SHALL remain present and be constant 0, and no flag logic is built.

Structure
- REQ-017 Package alu_core_pkg SHALL hold the opcode width (6) and the eight opcode constants (ADD, SUB, AND, OR, XOR, NOR, SRL, SRA).
- REQ-018 Sub-module alu_core_datapath SHALL hold the combinational result and flag generation; alu_core SHALL hold the registers and the reset.

Verification
- REQ-019 The reset test SHALL hold i_reset=1 with A=3, B=3, ADD and clock the block -> o_res=0; after release, one edge later -> o_res=8'd6.
- REQ-020 ADD/SUB/AND/OR/XOR SHALL be tested, one edge each:
  - ADD 3,3 -> 6
  - SUB 6,2 -> 4
  - AND 3,9 -> 1
  - OR 5,2 -> 7
  - XOR 7,2 -> 5
- REQ-021 The shift/NOR test SHALL check:
  - SRA 15,1 -> 7
  - SRL 16,2 -> 4
  - NOR 15,4 -> 8'hF0
  - SRA 8'h80,1 -> 8'hC0
  - SRL 8'h80,9 -> 0
- REQ-022 The flags test, with ALU_CORE_FLAGS_EN defined, SHALL check:
  - ADD 8'hFF,1 -> res 0, zero 1, carry 1, ovf 0
  - ADD 8'h7F,1 -> res 8'h80, ovf 1
  - Without the macro, all flags SHALL read 0.
- REQ-023 The illegal-opcode test SHALL drive i_Op=6'b111111 with A=5, B=5 -> o_res=0.
- REQ-024 The async-reset test SHALL assert i_reset between clock edges while o_res=6 -> o_res=0 before the next edge.

Source files
------------

// File: rtl/alu_core_pkg.sv
// alu_core_pkg: opcode width, opcode constants and a small opcode helper
// shared by the ALU datapath, the ALU register wrapper and its bench.
package alu_core_pkg;

    // Opcode field width (function-field style encoding).
    localparam int OP_W = 6;

    // Register-register arithmetic and logic operations.
    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    // Shifts: operand B supplies the shift amount.
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

    // True for the eight decoded opcodes; everything else yields result 0
    // and all flags 0.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core_datapath.sv
// alu_core_datapath: purely combinational result and status-flag generation.
// Flag outputs exist only when ALU_CORE_FLAGS_EN is defined; otherwise no
// flag logic is elaborated at all.
module alu_core_datapath
    import alu_core_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
`ifdef ALU_CORE_FLAGS_EN
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow,
`endif
    output logic [N_BITS-1:0] o_result
);

    // Shift amounts are compared in a field at least 32 bits wide so that
    // N_BITS itself is always representable next to the amount.
    localparam int CMP_W = (N_BITS > 32) ? N_BITS : 32;

    logic              shift_sat;
    logic [N_BITS-1:0] srl_res;
    logic [N_BITS-1:0] sra_res;

    // Shift saturation: amounts >= N_BITS shift every bit of A out.
    always_comb begin
        shift_sat = (CMP_W'(i_b) >= CMP_W'(N_BITS));
        srl_res   = '0;
        sra_res   = {N_BITS{i_a[N_BITS-1]}};
        if (!shift_sat) begin
            srl_res = i_a >> i_b;
            sra_res = $signed(i_a) >>> i_b;
        end
    end

    // Opcode decode and result selection; unknown opcodes give 0.
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_SRL:  o_result = srl_res;
            OP_SRA:  o_result = sra_res;
            default: o_result = '0;
        endcase
    end

`ifdef ALU_CORE_FLAGS_EN
    logic [N_BITS:0] add_full;
    logic [N_BITS:0] sub_full;
    logic            msb_a;
    logic            msb_b;
    logic            msb_r;

    // Status flags. SUB is formed as A + ~B + 1 so its carry-out is the
    // inverse of the borrow. Overflow is the usual sign-rule test on the
    // operand and result MSBs.
    always_comb begin
        add_full   = {1'b0, i_a} + {1'b0, i_b};
        sub_full   = {1'b0, i_a} + {1'b0, ~i_b} + {{N_BITS{1'b0}}, 1'b1};
        msb_a      = i_a[N_BITS-1];
        msb_b      = i_b[N_BITS-1];
        msb_r      = o_result[N_BITS-1];
        o_zero     = is_legal_op(i_op) && (o_result == '0);
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_carry    = add_full[N_BITS];
                o_overflow = (msb_a == msb_b) && (msb_r != msb_a);
            end
            OP_SUB: begin
                o_carry    = sub_full[N_BITS];
                o_overflow = (msb_a != msb_b) && (msb_r != msb_a);
            end
            default: begin
                o_carry    = 1'b0;
                o_overflow = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU. The datapath is combinational; this wrapper
// samples its result (and, with ALU_CORE_FLAGS_EN defined, its flags) on
// every rising i_clk edge and clears everything asynchronously on i_reset.
//
// Flow control: there is no valid/ready handshake. A new operation is taken
// on every rising edge and its result appears on o_res one edge later; the
// outputs reflect only the inputs present at the sampling edge.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int N_LEDS = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_BITS-1:0] i_A,
    input  logic [N_BITS-1:0] i_B,
    input  logic [OP_W-1:0]   i_Op,
    output logic [N_LEDS-1:0] o_res,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow
);

    logic [N_BITS-1:0] result;
    logic [N_LEDS-1:0] res_map;
    logic [N_LEDS-1:0] res_d;
    logic [N_LEDS-1:0] res_q;

`ifdef ALU_CORE_FLAGS_EN
    logic zero_c;
    logic carry_c;
    logic overflow_c;
    logic zero_d;
    logic carry_d;
    logic overflow_d;
    logic zero_q;
    logic carry_q;
    logic overflow_q;
`endif

    alu_core_datapath #(
        .N_BITS (N_BITS)
    ) u_datapath (
        .i_a        (i_A),
        .i_b        (i_B),
        .i_op       (i_Op),
`ifdef ALU_CORE_FLAGS_EN
        .o_zero     (zero_c),
        .o_carry    (carry_c),
        .o_overflow (overflow_c),
`endif
        .o_result   (result)
    );

    // Fit the N_BITS result onto the N_LEDS output: truncate or zero-extend.
    generate
        if (N_LEDS <= N_BITS) begin : g_res_trunc
            assign res_map = result[N_LEDS-1:0];
        end else begin : g_res_zext
            assign res_map = {{(N_LEDS - N_BITS){1'b0}}, result};
        end
    endgenerate

    // Next-state for the result register: always the current operation.
    always_comb begin
        res_d = '0;
        res_d = res_map;
    end

    // Result register; reset clears it immediately and drops any pending value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign o_res = res_q;

`ifdef ALU_CORE_FLAGS_EN
    // Next-state for the flag registers, same latency as the result.
    always_comb begin
        zero_d     = 1'b0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        zero_d     = zero_c;
        carry_d    = carry_c;
        overflow_d = overflow_c;
    end

    // Flag registers, cleared together with the result.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_zero     = zero_q;
    assign o_carry    = carry_q;
    assign o_overflow = overflow_q;
`else
    // Flags disabled: ports stay for a fixed pin-out, driven low.
    assign o_zero     = 1'b0;
    assign o_carry    = 1'b0;
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed literal checks plus randomized stimulus compared
// every cycle against an integer-arithmetic reference model of the ALU.
module tb_alu_core;
  import alu_core_pkg::*;

  localparam int N_BITS = 8;
  localparam int N_LEDS = 8;
  localparam int W      = N_LEDS + 3;   // {ovf, carry, zero, res}

  logic              clk;
  logic              rst;
  logic [N_BITS-1:0] a;
  logic [N_BITS-1:0] b;
  logic [OP_W-1:0]   op;
  logic [N_LEDS-1:0] res;
  logic              zero;
  logic              carry;
  logic              ovf;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  alu_core #(
    .N_BITS (N_BITS),
    .N_LEDS (N_LEDS)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_A        (a),
    .i_B        (b),
    .i_Op       (op),
    .o_res      (res),
    .o_zero     (zero),
    .o_carry    (carry),
    .o_overflow (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer arithmetic from the opcode table; returns {ovf,carry,zero,res}.
  function automatic logic [W-1:0] model(input logic [OP_W-1:0] f_op,
                                         input logic [N_BITS-1:0] fa,
                                         input logic [N_BITS-1:0] fb);
    int ua, ub, sa, sb, r;
    logic z, c, v, legal;
    ua = fa; ub = fb;
    sa = $signed(fa); sb = $signed(fb);
    c = 1'b0; v = 1'b0; legal = 1'b1; r = 0;
    case (f_op)
      6'b100000: begin
        r = (ua + ub) % 256; c = (ua + ub) > 255;
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      6'b100010: begin
        r = (ua - ub + 256) % 256; c = (ua >= ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = 255 - (ua | ub);
      6'b000010: r = (ub >= 8) ? 0 : (ua >> ub);
      6'b000011: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
      default: begin r = 0; legal = 1'b0; end
    endcase
    z = legal && (r == 0);
`ifndef ALU_CORE_FLAGS_EN
    z = 1'b0; c = 1'b0; v = 1'b0;
`endif
    return {v, c, z, 8'(r)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={ovf,carry,zero,res}=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected value of each edge: the model of the sampled inputs, or 0 in reset.
  always @(posedge clk) begin
    exp_q.push_back(rst ? '0 : model(op, a, b));
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
      check("reset_hold", {ovf, carry, zero, res}, '0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stream", {ovf, carry, zero, res}, e);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [OP_W-1:0] t_op, input logic [N_BITS-1:0] t_a,
                       input logic [N_BITS-1:0] t_b);
    @(posedge clk);
    #2;
    op = t_op; a = t_a; b = t_b;
  endtask

  // One operation, one edge later compare o_res with a hand-computed literal.
  task automatic run_op(input string name, input logic [OP_W-1:0] t_op,
                        input logic [N_BITS-1:0] t_a, input logic [N_BITS-1:0] t_b,
                        input logic [N_LEDS-1:0] exp_res);
    drive(t_op, t_a, t_b);
    @(posedge clk);
    #1;
    check(name, {3'b000, res}, {3'b000, exp_res});
  endtask

  // Same, but comparing the flags too.
  task automatic run_flags(input string name, input logic [OP_W-1:0] t_op,
                           input logic [N_BITS-1:0] t_a, input logic [N_BITS-1:0] t_b,
                           input logic [W-1:0] exp_all);
    drive(t_op, t_a, t_b);
    @(posedge clk);
    #1;
    check(name, {ovf, carry, zero, res}, exp_all);
  endtask

  // ---------------- stimulus ----------------
  logic [OP_W-1:0] op_tbl[8];

  initial begin
    op_tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA};

    // Reset hold with ADD 3,3 presented, then release.
    rst = 1'b1; a = 8'd3; b = 8'd3; op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check("reset_res", {3'b000, res}, '0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_add", {3'b000, res}, {3'b000, 8'd6});

    // Basic operations.
    run_op("add_3_3",   OP_ADD, 8'd3,   8'd3, 8'd6);
    run_op("sub_6_2",   OP_SUB, 8'd6,   8'd2, 8'd4);
    run_op("and_3_9",   OP_AND, 8'd3,   8'd9, 8'd1);
    run_op("or_5_2",    OP_OR,  8'd5,   8'd2, 8'd7);
    run_op("xor_7_2",   OP_XOR, 8'd7,   8'd2, 8'd5);

    // Shifts and NOR, including saturation boundaries.
    run_op("sra_15_1",  OP_SRA, 8'd15,  8'd1, 8'd7);
    run_op("srl_16_2",  OP_SRL, 8'd16,  8'd2, 8'd4);
    run_op("nor_15_4",  OP_NOR, 8'd15,  8'd4, 8'hF0);
    run_op("sra_80_1",  OP_SRA, 8'h80,  8'd1, 8'hC0);
    run_op("srl_80_9",  OP_SRL, 8'h80,  8'd9, 8'h00);
    run_op("srl_80_8",  OP_SRL, 8'h80,  8'd8, 8'h00);
    run_op("srl_80_7",  OP_SRL, 8'h80,  8'd7, 8'h01);
    run_op("sra_80_8",  OP_SRA, 8'h80,  8'd8, 8'hFF);
    run_op("sra_40_200", OP_SRA, 8'h40, 8'd200, 8'h00);
    run_op("sub_2_6",   OP_SUB, 8'd2,   8'd6, 8'hFC);

    // Illegal opcode.
    run_op("illegal_op", 6'b111111, 8'd5, 8'd5, 8'd0);

    // Flags.
`ifdef ALU_CORE_FLAGS_EN
    run_flags("flags_add_ff_1", OP_ADD, 8'hFF, 8'd1, {1'b0, 1'b1, 1'b1, 8'h00});
    run_flags("flags_add_7f_1", OP_ADD, 8'h7F, 8'd1, {1'b1, 1'b0, 1'b0, 8'h80});
    run_flags("flags_sub_2_6",  OP_SUB, 8'd2,  8'd6, {1'b0, 1'b0, 1'b0, 8'hFC});
    run_flags("flags_sub_6_2",  OP_SUB, 8'd6,  8'd2, {1'b0, 1'b1, 1'b0, 8'h04});
    run_flags("flags_and_zero", OP_AND, 8'hF0, 8'h0F, {1'b0, 1'b0, 1'b1, 8'h00});
    run_flags("flags_illegal",  6'b111111, 8'd0, 8'd0, {1'b0, 1'b0, 1'b0, 8'h00});
`else
    run_flags("flags_off_add_ff_1", OP_ADD, 8'hFF, 8'd1, {3'b000, 8'h00});
    run_flags("flags_off_add_7f_1", OP_ADD, 8'h7F, 8'd1, {3'b000, 8'h80});
`endif

    // Asynchronous reset between edges while o_res holds 6.
    run_op("async_pre", OP_ADD, 8'd3, 8'd3, 8'd6);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {ovf, carry, zero, res}, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Randomized stream with occasional mid-cycle reset pulses.
    repeat (600) begin
      int sel;
      logic [OP_W-1:0] r_op;
      logic [N_BITS-1:0] r_a, r_b;
      sel = $urandom_range(0, 9);
      if (sel < 8)       r_op = op_tbl[sel];
      else if (sel == 8) r_op = 6'($urandom);
      else               r_op = 6'b111111;
      r_a = 8'($urandom);
      r_b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      drive(r_op, r_a, r_b);
      rst = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #6;

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
